// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes used by the decoder,
// the hazard unit and the unit itself, plus the controller state encoding.
package md_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MADD  = 3'd4;
   localparam logic [2:0] MD_MADDU = 3'd5;
   localparam logic [2:0] MD_MTHI  = 3'd6;
   localparam logic [2:0] MD_MTLO  = 3'd7;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   // True for the divide ops, which take the longer latency.
   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for the single-cycle register moves.
   function automatic logic is_mt_op(input logic [2:0] op);
      return (op == MD_MTHI) || (op == MD_MTLO);
   endfunction

endpackage

// File: rtl/md_unit_param_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_param_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic [CNT_W-1:0] busy_cnt;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             done;

   modport master (
      output start, op, a, b, flush,
      input  busy, busy_cnt, hi, lo, done
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, busy_cnt, hi, lo, done
   );

endinterface

// File: rtl/md_calc.sv
// Combinational datapath: signed/unsigned multiply, multiply-accumulate onto
// the current HI/LO, and truncating divide with zero-divisor detection.
module md_calc
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div_zero
);

   logic               is_signed;
   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] acc;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   b_div;
   logic [WIDTH-1:0]   uq;
   logic [WIDTH-1:0]   ur;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   r;

   // Signed ops work on magnitudes and fix the signs afterwards; the most
   // negative value divided by -1 falls out as itself with a zero remainder.
   always_comb begin
      is_signed = (op == MD_MULT) || (op == MD_MADD) || (op == MD_DIV);

      a_ext = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      b_ext = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
      prod  = a_ext * b_ext;
      acc   = {hi_in, lo_in} + prod;

      a_neg = is_signed & a[WIDTH-1];
      b_neg = is_signed & b[WIDTH-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;

      div_zero = is_div_op(op) && (b == '0);
      b_div    = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
      uq       = a_mag / b_div;
      ur       = a_mag % b_div;
      q        = (a_neg ^ b_neg) ? -uq : uq;
      r        = a_neg ? -ur : ur;

      res_hi = hi_in;
      res_lo = lo_in;
      case (op)
         MD_MULT, MD_MULTU: {res_hi, res_lo} = prod;
         MD_MADD, MD_MADDU: {res_hi, res_lo} = acc;
         MD_DIV,  MD_DIVU:  {res_hi, res_lo} = {r, q};
         default:           {res_hi, res_lo} = {hi_in, lo_in};
      endcase
   end

endmodule

// File: rtl/md_unit_param.sv
// Multicycle multiply/divide unit with HI/LO, MADD, in-flight cancel and a
// busy countdown for the hazard unit. The result is computed at issue and held
// in shadow registers until the countdown expires.
module md_unit_param
   import md_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 5
) (
   input  logic             clk,
   input  logic             reset,
   md_unit_param_if.slave   bus
);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lat;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic [WIDTH-1:0] sh_hi;
   logic [WIDTH-1:0] sh_lo;
   logic             sh_keep;
   logic [WIDTH-1:0] calc_hi;
   logic [WIDTH-1:0] calc_lo;
   logic             calc_dz;

   md_calc #(.WIDTH(WIDTH)) u_calc (
      .op       (bus.op),
      .a        (bus.a),
      .b        (bus.b),
      .hi_in    (hi_r),
      .lo_in    (lo_r),
      .res_hi   (calc_hi),
      .res_lo   (calc_lo),
      .div_zero (calc_dz)
   );

   // Busy latency of the op being issued.
   always_comb begin
      lat = is_div_op(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
   end

   // Issue, countdown, commit and cancel; all outputs come straight from here.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         hi_r    <= '0;
         lo_r    <= '0;
         sh_hi   <= '0;
         sh_lo   <= '0;
         sh_keep <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (state == ST_IDLE) begin
            if (bus.start && !bus.flush) begin
               if (bus.op == MD_MTHI) begin
                  hi_r <= bus.a;
               end else if (bus.op == MD_MTLO) begin
                  lo_r <= bus.a;
               end else begin
                  sh_hi   <= calc_hi;
                  sh_lo   <= calc_lo;
                  sh_keep <= calc_dz;
                  cnt     <= lat;
                  busy_r  <= 1'b1;
                  state   <= ST_RUN;
               end
            end
         end else begin
            if (bus.flush) begin
               cnt    <= '0;
               busy_r <= 1'b0;
               state  <= ST_IDLE;
            end else if (cnt == CNT_W'(1)) begin
               if (!sh_keep) begin
                  hi_r <= sh_hi;
                  lo_r <= sh_lo;
               end
               done_r <= 1'b1;
               cnt    <= '0;
               busy_r <= 1'b0;
               state  <= ST_IDLE;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end

   assign bus.busy     = busy_r;
   assign bus.busy_cnt = cnt;
   assign bus.hi       = hi_r;
   assign bus.lo       = lo_r;
   assign bus.done     = done_r;

endmodule

// File: tb/tb_md_unit_param.sv
// Directed plus randomized checks of md_unit_param against a plain-arithmetic
// model of HI/LO and the busy/done timing.
module tb_md_unit_param;
   import md_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   md_unit_param_if #(.WIDTH(32), .CNT_W(5)) bus();

   md_unit_param #(
      .WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int nvec = 0;
   int nmis = 0;
   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int latency(input logic [2:0] op);
      return ((op == MD_DIV) || (op == MD_DIVU)) ? 10 : 5;
   endfunction

   function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur);
      int sa, sb, q, r;
      longint sp;
      logic [63:0] up;
      sa = $signed(a);
      sb = $signed(b);
      sp = longint'(sa) * longint'(sb);
      up = {32'h0, a} * {32'h0, b};
      case (op)
         MD_MULT:  return 64'(sp);
         MD_MULTU: return up;
         MD_MADD:  return cur + 64'(sp);
         MD_MADDU: return cur + up;
         MD_DIV: begin
            if (b == 32'h0) return cur;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         MD_DIVU:  return (b == 32'h0) ? cur : {a % b, a / b};
         MD_MTHI:  return {a, cur[31:0]};
         default:  return {cur[63:32], a};
      endcase
   endfunction

   // Issue one op and follow it cycle by cycle; flush_at / poke_at name the
   // busy_cnt value at which to flush or to attempt an MTLO of 0x99 (0 = never).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int poke_at);
      logic [63:0] exp;
      int l;
      exp = ref_result(op, a, b, {mhi, mlo});
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0;
      if ((op == MD_MTHI) || (op == MD_MTLO)) begin
         chk("mt_hilo", {bus.hi, bus.lo}, exp);
         chk("mt_busy", 64'(bus.busy), 64'd0);
         {mhi, mlo} = exp;
         return;
      end
      l = latency(op);
      for (int k = l; k >= 1; k--) begin
         chk("run_busy", 64'(bus.busy), 64'd1);
         chk("run_cnt", 64'(bus.busy_cnt), 64'(k));
         chk("run_hold", {bus.hi, bus.lo}, {mhi, mlo});
         chk("run_done", 64'(bus.done), 64'd0);
         if (k == poke_at) begin
            bus.start = 1'b1; bus.op = MD_MTLO; bus.a = 32'h99;
         end
         if (k == flush_at) bus.flush = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         bus.flush = 1'b0;
         if (k == flush_at) begin
            chk("flush_busy", 64'(bus.busy), 64'd0);
            chk("flush_cnt", 64'(bus.busy_cnt), 64'd0);
            chk("flush_done", 64'(bus.done), 64'd0);
            chk("flush_hilo", {bus.hi, bus.lo}, {mhi, mlo});
            return;
         end
      end
      chk("end_busy", 64'(bus.busy), 64'd0);
      chk("end_cnt", 64'(bus.busy_cnt), 64'd0);
      chk("end_done", 64'(bus.done), 64'd1);
      chk("end_hilo", {bus.hi, bus.lo}, exp);
      {mhi, mlo} = exp;
      @(negedge clk);
      chk("done_pulse", 64'(bus.done), 64'd0);
   endtask

   initial begin
      logic [2:0] rop;
      logic [31:0] ra, rb;
      int rf;

      bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_cnt", 64'(bus.busy_cnt), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      reset = 1'b1;

      run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, 0, 0);
      chk("tp_mult", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0);
      chk("tp_multu", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);

      run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
      chk("tp_div", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      chk("tp_div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

      run_op(MD_MTLO, 32'd5, 32'd0, 0, 0);
      run_op(MD_MTHI, 32'd0, 32'd0, 0, 0);
      run_op(MD_MADD, 32'd3, 32'd4, 0, 0);
      chk("tp_madd", {bus.hi, bus.lo}, 64'd17);
      run_op(MD_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      chk("tp_maddu", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0012);

      run_op(MD_MTHI, 32'h11, 32'd0, 0, 0);
      run_op(MD_MTLO, 32'h22, 32'd0, 0, 0);
      run_op(MD_DIVU, 32'd100, 32'd0, 3, 0);
      chk("tp_flush", {bus.hi, bus.lo}, {32'h11, 32'h22});
      run_op(MD_DIVU, 32'd100, 32'd0, 0, 0);
      chk("tp_div0", {bus.hi, bus.lo}, {32'h11, 32'h22});

      run_op(MD_DIV, 32'd100, 32'd7, 0, 4);
      chk("tp_poke", {bus.hi, bus.lo}, {32'd2, 32'd14});

      @(negedge clk);
      bus.start = 1'b1; bus.op = MD_MTHI; bus.a = 32'hAB; bus.flush = 1'b1;
      @(negedge clk);
      bus.op = MD_MULT; bus.b = 32'd3;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("sf_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
      chk("sf_busy", 64'(bus.busy), 64'd0);
      chk("sf_cnt", 64'(bus.busy_cnt), 64'd0);

      @(negedge clk);
      bus.start = 1'b1; bus.op = MD_MULT; bus.a = 32'd5; bus.b = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rm_cnt", 64'(bus.busy_cnt), 64'd2);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("rm_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("rm_busy", 64'(bus.busy), 64'd0);
      chk("rm_cnt0", 64'(bus.busy_cnt), 64'd0);
      chk("rm_done", 64'(bus.done), 64'd0);
      mhi = '0; mlo = '0;
      @(negedge clk);
      chk("rm_done_after", 64'(bus.done), 64'd0);
      run_op(MD_MULT, 32'd2, 32'd3, 0, 0);
      chk("tp_after_rst", {bus.hi, bus.lo}, 64'd6);

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
         if ($urandom_range(0, 15) == 0) begin
            ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
         end
         rf = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : 0;
         run_op(rop, ra, rb, rf, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/md_unit_param.md
# md_unit_param

Parametrised multiply/divide unit for the EX stage of the 5-stage pipeline, replacing the fixed-latency HI/LO unit. It supports configurable data width and per-operation latency, adds multiply-accumulate and in-flight cancel, and exports `busy` and `busy_cnt` for the hazard unit's stall decision. All outputs are registered.

## Interface
- `WIDTH`, 32, operand and HI/LO width.
- `MULT_CYCLES`, 5, busy cycles for MULT/MULTU/MADD/MADDU (≥1).
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU (≥1).
- `CNT_W`, 5, `busy_cnt` width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset on the next rising edge).
- `start`  in  1  issue `op` this cycle.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MTHI, 7 MTLO.
- `a`  in  WIDTH  rs operand.
- `b`  in  WIDTH  rt operand.
- `flush`  in  1  abort the in-flight operation and any same-cycle start.
- `busy`  out  1  an operation is in flight.
- `busy_cnt`  out  CNT_W  remaining busy cycles; 0 when idle.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `done`  out  1  one-cycle pulse when a multicycle result first appears on `hi`/`lo`.

## Operation
- States: IDLE, RUN.
- Reset: `hi`=0, `lo`=0, `busy`=0, `busy_cnt`=0, `done`=0, state IDLE. Reset applies in any state and drops an in-flight operation.
- IDLE with `start`=1 and `flush`=0:
  - op 0–5: latch the computed result into shadow registers, load the counter with the op latency, go to RUN.
  - op 6/7: write `a` to `hi`/`lo` at this edge, stay IDLE, `busy` stays 0.
- RUN: `start` is ignored, including MTHI/MTLO; the hazard unit must stall these. The counter decrements each cycle. When it moves 1→0, the shadow result commits to `hi`/`lo` and the unit returns to IDLE.
- `flush`=1 in RUN: return to IDLE at the next edge. Shadow result discarded, `hi`/`lo` unchanged, no `done`.
- `flush`=1 in IDLE: suppresses a same-cycle `start`, including MTHI/MTLO.
- Arithmetic:
  - MULT/MULTU: full 2·WIDTH product, signed or unsigned; `{hi,lo}` = product.
  - MADD/MADDU: `{hi,lo}` = `{hi,lo}` sampled at start + product, modulo 2^(2·WIDTH).
  - DIV: quotient to `lo`, truncated toward zero. Remainder to `hi`, with the sign of the dividend.
  - DIV of most-negative value by −1: `lo` = most-negative value, `hi` = 0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (DIV/DIVU): full DIV_CYCLES elapse, `hi`/`lo` unchanged, `done` still pulses.

## Timing
- Start sampled at edge of cycle n:
  - `busy`=1 in cycles n+1 … n+L (L = op latency).
  - `busy_cnt` = L in cycle n+1, decrementing to 1 in cycle n+L.
- Result visible on `hi`/`lo` in cycle n+L+1. In that cycle `busy`=0, `busy_cnt`=0, `done`=1.
- A new start is accepted in cycle n+L+1, so back-to-back ops have a gap of L cycles.
- MTHI/MTLO: new value visible in cycle n+1.
- `hi`/`lo` hold their old values for the whole of RUN. Readers (MFHI/MFLO) stall on `busy` or `start`.
- `flush` in cycle m during RUN: `busy`=0 and `busy_cnt`=0 in cycle m+1.

## Structure
- Shared package `md_pkg`: op encoding localparams (`MD_MULT` … `MD_MTLO`) and state encoding. Imported by this unit, the decoder and the hazard unit.
- One sub-module `md_calc`: combinational signed/unsigned multiply, MADD accumulate and divide over `WIDTH`, including the zero-divisor and overflow special cases. The parent holds the FSM, counter, shadow registers and HI/LO.

## Test plan
All scenarios use WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
- MULT a=0xFFFFFFFF, b=2 → `busy` for 5 cycles with `busy_cnt` 5,4,3,2,1; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, `done`=1. Then MULTU with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTLO a=5, MTHI a=0, then MADD a=3, b=4 → `lo`=17, `hi`=0 after 5 busy cycles. Then MADDU a=0xFFFFFFFF, b=0xFFFFFFFF → `{hi,lo}`=0xFFFFFFFE_00000012.
- Preset `hi`=0x11, `lo`=0x22; DIVU a=100, b=0; assert `flush` when `busy_cnt`=3 → `busy`=0 next cycle, `hi`=0x11, `lo`=0x22, no `done`. Repeat without the flush → `done` after 10 cycles, `hi`/`lo` unchanged.
- Start MTLO a=0x99 while `busy` → `lo` unchanged. `start`+`flush` in IDLE → nothing happens.
- `reset`=0 mid-MULT at `busy_cnt`=2 → next cycle all outputs 0. Later MULT a=2, b=3 behaves normally (`lo`=6).
